// File: rtl/ltl_mon_pkg.sv
// Shared types for the LTL monitor controller.
// Holds the controller state encoding, the verdict record layout for the default
// configuration and the "no hit" index marker.
package ltl_mon_pkg;

  localparam int unsigned NumSrcDef = 2;
  localparam int unsigned SymWDef   = 8;
  localparam int unsigned NumRptDef = 4;
  localparam int unsigned IdxWDef   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StInit,
    StStream,
    StDrain,
    StReport
  } state_e;

  typedef struct packed {
    logic [$clog2(NumSrcDef)-1:0] src;
    logic [NumRptDef-1:0]         vec;
    logic [IdxWDef-1:0]           idx;
  } verdict_t;

  // All-ones index is reserved to mean "no report line fired during the session".
  localparam logic [IdxWDef-1:0] IDX_NONE = '1;

endpackage

// File: rtl/ltl_monitor_ctrl_if.sv
// Bus bundle between the LTL monitor controller and its environment.
// Carries the per-source symbol streams, the engine drive/report lines, the
// verdict record handshake and the busy flag.
//   master : controller side (drives src_ready, eng_*, rpt_valid/src/vec/idx, busy)
//   slave  : environment side (drives src_valid/sym/last, eng_report, rpt_ready)
interface ltl_monitor_ctrl_if #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned SYM_W   = 8,
  parameter int unsigned NUM_RPT = 4,
  parameter int unsigned IDX_W   = 16
);

  localparam int unsigned SrcW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*SYM_W-1:0] src_sym;
  logic [NUM_SRC-1:0]       src_last;
  logic [NUM_SRC-1:0]       src_ready;
  logic                     eng_reset;
  logic                     eng_run;
  logic [SYM_W-1:0]         eng_sym;
  logic [NUM_RPT-1:0]       eng_report;
  logic                     rpt_valid;
  logic                     rpt_ready;
  logic [SrcW-1:0]          rpt_src;
  logic [NUM_RPT-1:0]       rpt_vec;
  logic [IDX_W-1:0]         rpt_idx;
  logic                     busy;

  modport master (
    input  src_valid, src_sym, src_last, eng_report, rpt_ready,
    output src_ready, eng_reset, eng_run, eng_sym, rpt_valid, rpt_src, rpt_vec, rpt_idx, busy
  );

  modport slave (
    output src_valid, src_sym, src_last, eng_report, rpt_ready,
    input  src_ready, eng_reset, eng_run, eng_sym, rpt_valid, rpt_src, rpt_vec, rpt_idx, busy
  );

endinterface

// File: rtl/ltl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the lowest requesting index at or above ptr_i, wrapping around.
//   req_i       : request vector
//   ptr_i       : priority pointer (must be < NUM_SRC)
//   gnt_o       : one-hot grant
//   gnt_idx_o   : binary index of the grant
//   gnt_valid_o : any request present
module ltl_rr_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  localparam int unsigned SrcW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SrcW-1:0]    ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [SrcW-1:0]    gnt_idx_o,
  output logic               gnt_valid_o
);

  always_comb begin
    int unsigned cand;
    cand        = 0;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = SrcW'(cand);
      end
    end
  end

endmodule

// File: rtl/ltl_monitor_ctrl.sv
// Session sequencer in front of one LTL automaton cluster.
// Grants the engine to one symbol source per session (round robin), pulses the
// engine reset to create start_of_data, streams symbols, accumulates the report
// lines and hands back a verdict record.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus_io     : source streams, engine lines, verdict handshake, busy
module ltl_monitor_ctrl
  import ltl_mon_pkg::*;
#(
  parameter int unsigned NUM_SRC = NumSrcDef,
  parameter int unsigned SYM_W   = SymWDef,
  parameter int unsigned NUM_RPT = NumRptDef,
  parameter int unsigned IDX_W   = IdxWDef
) (
  input logic                clk,
  input logic                rst_n,
  ltl_monitor_ctrl_if.master bus_io
);

  localparam int unsigned SrcW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W-1:0] IdxNone = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IdxSat  = {{(IDX_W-1){1'b1}}, 1'b0};

  state_e               state_q, state_d;
  logic [SrcW-1:0]      grant_q, grant_d;
  logic [NUM_SRC-1:0]   grant_oh_q, grant_oh_d;
  logic [SrcW-1:0]      ptr_q, ptr_d;
  logic [SYM_W-1:0]     hold_sym_q, hold_sym_d;
  logic                 hold_last_q, hold_last_d;
  logic                 first_q, first_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     samp_idx_q;
  logic                 run_q;
  logic [NUM_RPT-1:0]   vec_q, vec_d;
  logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;

  logic [NUM_SRC-1:0]   arb_gnt;
  logic [SrcW-1:0]      arb_idx;
  logic                 arb_valid;

  logic                 sel_valid;
  logic                 sel_last;
  logic [SYM_W-1:0]     sel_sym;

  ltl_rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .req_i       (bus_io.src_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  assign sel_valid = bus_io.src_valid[grant_q];
  assign sel_last  = bus_io.src_last[grant_q];
  assign sel_sym   = bus_io.src_sym[32'(grant_q) * SYM_W +: SYM_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      ptr_q       <= '0;
      hold_sym_q  <= '0;
      hold_last_q <= 1'b0;
      first_q     <= 1'b0;
      idx_q       <= '0;
      samp_idx_q  <= '0;
      run_q       <= 1'b0;
      vec_q       <= '0;
      hit_idx_q   <= IdxNone;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      ptr_q       <= ptr_d;
      hold_sym_q  <= hold_sym_d;
      hold_last_q <= hold_last_d;
      first_q     <= first_d;
      idx_q       <= idx_d;
      // Engine reports one cycle after a run cycle; remember which symbol that was.
      samp_idx_q  <= idx_q;
      run_q       <= bus_io.eng_run;
      vec_q       <= vec_d;
      hit_idx_q   <= hit_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    ptr_d       = ptr_q;
    hold_sym_d  = hold_sym_q;
    hold_last_d = hold_last_q;
    first_d     = first_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    hit_idx_d   = hit_idx_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_gnt;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        if (sel_valid) begin
          hold_sym_d  = sel_sym;
          hold_last_d = sel_last;
          state_d     = StInit;
        end
      end
      StInit: begin
        first_d = 1'b1;
        state_d = StStream;
      end
      StStream: begin
        if (first_q) begin
          first_d = 1'b0;
          if (hold_last_q) state_d = StDrain;
        end else if (sel_valid && sel_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StReport;
      end
      StReport: begin
        if (bus_io.rpt_ready) begin
          ptr_d   = (grant_q == SrcW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StInit) begin
      idx_d     = '0;
      vec_d     = '0;
      hit_idx_d = IdxNone;
    end else begin
      if (bus_io.eng_run && (idx_q != IdxSat)) idx_d = idx_q + 1'b1;
      if (run_q) begin
        vec_d = vec_q | bus_io.eng_report;
        if ((bus_io.eng_report != '0) && (hit_idx_q == IdxNone)) hit_idx_d = samp_idx_q;
      end
    end
  end

  always_comb begin
    bus_io.src_ready = '0;
    bus_io.eng_reset = 1'b0;
    bus_io.eng_run   = 1'b0;
    bus_io.eng_sym   = '0;
    bus_io.rpt_valid = 1'b0;

    unique case (state_q)
      StIdle: bus_io.eng_reset = 1'b1;
      StLoad: begin
        bus_io.eng_reset = 1'b1;
        bus_io.src_ready = grant_oh_q;
      end
      StInit: bus_io.eng_reset = 1'b1;
      StStream: begin
        if (first_q) begin
          // start_of_data cycle: replay the symbol captured during LOAD.
          bus_io.eng_run = 1'b1;
          bus_io.eng_sym = hold_sym_q;
        end else begin
          bus_io.src_ready = grant_oh_q;
          bus_io.eng_run   = sel_valid;
          bus_io.eng_sym   = sel_sym;
        end
      end
      StDrain: ;
      StReport: bus_io.rpt_valid = 1'b1;
      default: bus_io.eng_reset = 1'b1;
    endcase
  end

  assign bus_io.rpt_src = grant_q;
  assign bus_io.rpt_vec = vec_q;
  assign bus_io.rpt_idx = hit_idx_q;
  assign bus_io.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_ltl_monitor_ctrl.sv
// Directed bench for ltl_monitor_ctrl with a latency-1 engine stub.
module tb_ltl_monitor_ctrl;
  import ltl_mon_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ltl_monitor_ctrl_if #(.NUM_SRC(2), .SYM_W(8), .NUM_RPT(4), .IDX_W(16)) bus ();

  ltl_monitor_ctrl #(.NUM_SRC(2), .SYM_W(8), .NUM_RPT(4), .IDX_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  logic       v0, v1, l0, l1;
  logic [7:0] s0, s1;
  assign bus.src_valid = {v1, v0};
  assign bus.src_sym   = {s1, s0};
  assign bus.src_last  = {l1, l0};

  logic [3:0] rpt_tab [16];
  int         eng_cnt;
  int         run_cnt;
  logic       prev_rst;
  logic       abort;
  logic [7:0] exp_first_q [$];
  int         n_checks;
  int         n_errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Engine stub: report registered one cycle after a run cycle, noise otherwise.
  always @(posedge clk) begin
    if (bus.eng_reset) begin
      eng_cnt        <= 0;
      bus.eng_report <= 4'b0000;
    end else if (bus.eng_run) begin
      bus.eng_report <= rpt_tab[eng_cnt[3:0]];
      eng_cnt        <= eng_cnt + 1;
    end else begin
      bus.eng_report <= 4'b1000;
    end
  end

  // Observer: grant exclusivity, start_of_data symbol, run-cycle count.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rst <= 1'b1;
      run_cnt  <= 0;
    end else begin
      check_eq("ready_onehot", 32'($countones(bus.src_ready) <= 1), 1);
      if (prev_rst && !bus.eng_reset) begin
        check_eq("sod_run", bus.eng_run, 1);
        check_eq("sod_queue", 32'(exp_first_q.size() > 0), 1);
        if (exp_first_q.size() > 0) check_eq("sod_sym", bus.eng_sym, exp_first_q.pop_front());
      end
      prev_rst <= bus.eng_reset;
      if (bus.eng_reset) run_cnt <= 0;
      else if (bus.eng_run) run_cnt <= run_cnt + 1;
    end
  end

  task automatic set_src(input int s, input logic v, input logic [7:0] d, input logic l);
    if (s == 0) begin v0 = v; s0 = d; l0 = l; end
    else begin v1 = v; s1 = d; l1 = l; end
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 16; i++) rpt_tab[i] = 4'b0000;
  endtask

  // Sends n symbols base, base+1, ...; gap_mask bit k inserts one idle cycle before symbol k.
  task automatic drive_src(input int s, input int n, input logic [7:0] base, input int gap_mask);
    logic acc;
    int   t;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      if (abort) break;
      if (gap_mask[k]) begin
        set_src(s, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;
      end
      set_src(s, 1'b1, base + 8'(k), (k == n - 1));
      acc = 1'b0;
      t   = 0;
      while (!acc && !abort && t < 200) begin
        @(negedge clk);
        acc = bus.src_valid[s] && bus.src_ready[s];
        t++;
      end
      if (!abort) check_eq($sformatf("accept_s%0d_k%0d", s, k), acc, 1);
      @(posedge clk); #1;
    end
    set_src(s, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic expect_verdict(input string tag, input int src, input logic [3:0] vec,
                                input logic [15:0] idx, input int runs, input int hold);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.rpt_valid && t < 400);
    check_eq({tag, "_valid"}, bus.rpt_valid, 1);
    check_eq({tag, "_src"}, bus.rpt_src, src);
    check_eq({tag, "_vec"}, bus.rpt_vec, vec);
    check_eq({tag, "_idx"}, bus.rpt_idx, idx);
    check_eq({tag, "_runs"}, run_cnt, runs);
    check_eq({tag, "_busy"}, bus.busy, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq($sformatf("%s_hold%0d_valid", tag, h), bus.rpt_valid, 1);
      check_eq($sformatf("%s_hold%0d_vec", tag, h), bus.rpt_vec, vec);
      check_eq($sformatf("%s_hold%0d_idx", tag, h), bus.rpt_idx, idx);
      check_eq($sformatf("%s_hold%0d_src", tag, h), bus.rpt_src, src);
    end
    bus.rpt_ready = 1'b1;
    @(posedge clk); #1;
    bus.rpt_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, bus.busy, 0);
    check_eq({tag, "_idle_engrst"}, bus.eng_reset, 1);
    check_eq({tag, "_idle_valid"}, bus.rpt_valid, 0);
  endtask

  task automatic watch_init();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.src_ready[0] && t < 100);
    check_eq("t1_load_ready", bus.src_ready[0], 1);
    @(negedge clk);
    check_eq("t1_init_engrst", bus.eng_reset, 1);
    check_eq("t1_init_run", bus.eng_run, 0);
    check_eq("t1_init_ready", bus.src_ready, 0);
    @(negedge clk);
    check_eq("t1_s0_engrst", bus.eng_reset, 0);
    check_eq("t1_s0_run", bus.eng_run, 1);
    check_eq("t1_s0_sym", bus.eng_sym, 8'h10);
  endtask

  task automatic reset_in_stream();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (run_cnt < 2 && t < 200);
    check_eq("t6_reached_stream", 32'(run_cnt >= 2), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_engrst", bus.eng_reset, 1);
    check_eq("t6_run", bus.eng_run, 0);
    check_eq("t6_busy", bus.busy, 0);
    check_eq("t6_ready", bus.src_ready, 0);
    check_eq("t6_valid", bus.rpt_valid, 0);
    check_eq("t6_vec", bus.rpt_vec, 0);
    check_eq("t6_idx", bus.rpt_idx, IDX_NONE);
    abort = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    abort    = 1'b0;
    v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0; s0 = 8'h00; s1 = 8'h00;
    bus.rpt_ready = 1'b0;
    clear_tab();

    repeat (3) @(negedge clk);
    check_eq("rst_engrst", bus.eng_reset, 1);
    check_eq("rst_run", bus.eng_run, 0);
    check_eq("rst_sym", bus.eng_sym, 0);
    check_eq("rst_ready", bus.src_ready, 0);
    check_eq("rst_valid", bus.rpt_valid, 0);
    check_eq("rst_vec", bus.rpt_vec, 0);
    check_eq("rst_idx", bus.rpt_idx, 16'hFFFF);
    check_eq("rst_src", bus.rpt_src, 0);
    check_eq("rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three symbols from src0, no reports.
    exp_first_q.push_back(8'h10);
    fork
      drive_src(0, 3, 8'h10, 0);
      watch_init();
      expect_verdict("t1", 0, 4'b0000, 16'hFFFF, 3, 0);
    join

    // Src1, hits after symbols 1 and 3.
    clear_tab();
    rpt_tab[1] = 4'b0100;
    rpt_tab[3] = 4'b0001;
    exp_first_q.push_back(8'h50);
    fork
      drive_src(1, 4, 8'h50, 0);
      expect_verdict("t2", 1, 4'b0101, 16'd1, 4, 0);
    join

    // Contention: src0, src1, then src0's second request.
    clear_tab();
    rpt_tab[1] = 4'b0010;
    exp_first_q.push_back(8'h20);
    exp_first_q.push_back(8'h30);
    exp_first_q.push_back(8'h40);
    fork
      begin
        drive_src(0, 2, 8'h20, 0);
        drive_src(0, 2, 8'h40, 0);
      end
      drive_src(1, 2, 8'h30, 0);
      begin
        expect_verdict("t3a", 0, 4'b0010, 16'd1, 2, 0);
        expect_verdict("t3b", 1, 4'b0010, 16'd1, 2, 0);
        expect_verdict("t3c", 0, 4'b0010, 16'd1, 2, 0);
      end
    join

    // Valid gaps before symbols 2 and 3; hit on symbol 3.
    clear_tab();
    rpt_tab[3] = 4'b0100;
    exp_first_q.push_back(8'h60);
    fork
      drive_src(0, 5, 8'h60, 32'b01100);
      expect_verdict("t4", 0, 4'b0100, 16'd3, 5, 0);
    join

    // Single-symbol session.
    clear_tab();
    rpt_tab[0] = 4'b0011;
    exp_first_q.push_back(8'h70);
    fork
      drive_src(0, 1, 8'h70, 0);
      expect_verdict("t5", 0, 4'b0011, 16'd0, 1, 0);
    join

    // Reset mid-stream on a src1 session.
    clear_tab();
    rpt_tab[0] = 4'b0001;
    exp_first_q.push_back(8'h80);
    fork
      drive_src(1, 6, 8'h80, 0);
      reset_in_stream();
    join
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    abort = 1'b0;

    // Both request after reset: pointer back at 0; src0 verdict held with rpt_ready low.
    clear_tab();
    rpt_tab[0] = 4'b0100;
    exp_first_q.push_back(8'hA0);
    exp_first_q.push_back(8'h90);
    fork
      drive_src(0, 1, 8'hA0, 0);
      drive_src(1, 1, 8'h90, 0);
      begin
        expect_verdict("t7a", 0, 4'b0100, 16'd0, 1, 4);
        expect_verdict("t7b", 1, 4'b0100, 16'd0, 1, 0);
      end
    join

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
